pipe_muldiv: RTL and testbench

- Iterative multiply/divide unit in the EX stage of the 5-stage pipeline, directly upstream of the MEM stage.
- Executes MULT/MULTU/DIV/DIVU on the EX operands and holds the architectural HI/LO registers.
- HI/LO are read by MFHI/MFLO through the EX result mux and forwarded as the EX result into the EX/MEM register.
- Asserts busy so the hazard unit can stall the pipeline while an operation is in flight.

---
 rtl/pipe_muldiv.sv | 194 +++++++++++++++++++
 tb/tb_pipe_muldiv.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_muldiv.sv
// Iterative multiply/divide unit for the EX stage.
// Holds the architectural HI/LO registers and runs MULT/MULTU/DIV/DIVU
// as a WIDTH-step shift-add / restoring-division sequence on operand
// magnitudes, with the signs applied in a final FIX cycle.
module pipe_muldiv #(
    parameter int WIDTH = 32,
    parameter int CNTW  = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] ea,
    input  logic [WIDTH-1:0] eb,
    input  logic             whi,
    input  logic             wlo,
    input  logic             flush,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam int W2 = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    // Control state
    state_t            state_q, state_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [WIDTH-1:0]  hi_q, hi_d;
    logic [WIDTH-1:0]  lo_q, lo_d;

    // Datapath state (no reset needed: always loaded on start)
    logic [1:0]        op_q, op_d;
    logic              sa_q, sa_d;      // dividend / multiplicand sign (signed ops only)
    logic              sb_q, sb_d;      // divisor / multiplier sign (signed ops only)
    logic              dz_q, dz_d;      // divide by zero
    logic [WIDTH-1:0]  b_q, b_d;        // multiplicand magnitude or divisor magnitude
    logic [W2-1:0]     acc_q, acc_d;    // product accumulator, or {0, dividend->quotient}
    logic [WIDTH-1:0]  rem_q, rem_d;    // partial remainder

    // Step datapath
    logic [WIDTH:0]    mul_sum;
    logic [WIDTH:0]    div_shift;
    logic              div_ge;
    logic [WIDTH-1:0]  div_diff;
    logic [W2-1:0]     prod;
    logic              ld_sa, ld_sb;

    // Conditional two's-complement negation.
    function automatic logic [WIDTH-1:0] cneg(input logic [WIDTH-1:0] v, input logic neg);
        logic signed [WIDTH-1:0] sv;
        sv = signed'(v);
        return neg ? unsigned'(-sv) : v;
    endfunction

    // Radix-2 multiply: add multiplicand into the upper half when the low
    // bit of the multiplier is set, then shift the whole accumulator right.
    assign mul_sum = {1'b0, acc_q[W2-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);

    // Restoring divide: the 33-bit trial remainder is the old remainder
    // shifted left with the next dividend bit brought in.
    assign div_shift = {rem_q, acc_q[WIDTH-1]};
    assign div_ge    = (div_shift >= {1'b0, b_q});
    assign div_diff  = div_shift[WIDTH-1:0] - b_q;

    assign prod  = (sa_q ^ sb_q) ? -acc_q : acc_q;
    assign ld_sa = ~op[0] & ea[WIDTH-1];
    assign ld_sb = ~op[0] & eb[WIDTH-1];

    // Next-state, step and result logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        hi_d    = hi_q;
        lo_d    = lo_q;
        op_d    = op_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        dz_d    = dz_q;
        b_d     = b_q;
        acc_d   = acc_q;
        rem_d   = rem_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d    = op;
                    sa_d    = ld_sa;
                    sb_d    = ld_sb;
                    dz_d    = op[1] && (eb == '0);
                    rem_d   = '0;
                    cnt_d   = '0;
                    if (op[1]) begin
                        acc_d = {{WIDTH{1'b0}}, cneg(ea, ld_sa)};
                        b_d   = cneg(eb, ld_sb);
                    end else begin
                        acc_d = {{WIDTH{1'b0}}, cneg(eb, ld_sb)};
                        b_d   = cneg(ea, ld_sa);
                    end
                    state_d = S_CALC;
                    busy_d  = 1'b1;
                end else begin
                    if (whi) hi_d = ea;
                    if (wlo) lo_d = ea;
                end
            end

            S_CALC: begin
                if (flush) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    if (op_q[1]) begin
                        rem_d = div_ge ? div_diff : div_shift[WIDTH-1:0];
                        acc_d = {acc_q[W2-1:WIDTH], acc_q[WIDTH-2:0], div_ge};
                    end else begin
                        acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                    end
                    cnt_d = cnt_q + CNTW'(1);
                    if (cnt_q == CNTW'(WIDTH - 1)) state_d = S_FIX;
                end
            end

            S_FIX: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                if (!flush) begin
                    done_d = 1'b1;
                    if (!op_q[1]) begin
                        hi_d = prod[W2-1:WIDTH];
                        lo_d = prod[WIDTH-1:0];
                    end else if (dz_q) begin
                        hi_d = cneg(rem_q, sa_q);
                        lo_d = '1;
                    end else begin
                        hi_d = cneg(rem_q, sa_q);
                        lo_d = cneg(acc_q[WIDTH-1:0], sa_q ^ sb_q);
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Control and architectural registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Operand and iteration datapath registers.
    always_ff @(posedge clock) begin
        op_q  <= op_d;
        sa_q  <= sa_d;
        sb_q  <= sb_d;
        dz_q  <= dz_d;
        b_q   <= b_d;
        acc_q <= acc_d;
        rem_q <= rem_d;
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_pipe_muldiv.sv
// Self-checking bench for pipe_muldiv: directed vector table, random
// operations against an arithmetic reference model, and hand-written
// flush / reset / ignored-request sequences.
module tb_pipe_muldiv;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] ea, eb;
    logic        whi, wlo, flush;
    logic [31:0] hi, lo;
    logic        busy, done;

    int errors = 0;
    int checks = 0;

    pipe_muldiv #(.WIDTH(32), .CNTW(5)) dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .op    (op),
        .ea    (ea),
        .eb    (eb),
        .whi   (whi),
        .wlo   (wlo),
        .flush (flush),
        .hi    (hi),
        .lo    (lo),
        .busy  (busy),
        .done  (done)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic, returns {hi, lo}.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (o)
            2'b00: return 64'(sa * sb);
            2'b01: return ua * ub;
            2'b10: begin
                if (b == 0) return {a, 32'hFFFFFFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 0) return {a, 32'hFFFFFFFF};
                return {ua[31:0] % ub[31:0], ua[31:0] / ub[31:0]};
            end
        endcase
    endfunction

    // Step one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Issue one operation and wait (bounded) for done; checks busy length and result.
    task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
        int nb;
        bit seen;
        nb = 0;
        seen = 0;
        start = 1'b1; op = o; ea = a; eb = b;
        tick();
        start = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (done) begin
                seen = 1;
                break;
            end
            if (busy) nb++;
            tick();
        end
        chk({name, "_done"}, 64'(seen), 64'd1);
        chk({name, "_busycyc"}, 64'(nb), 64'd33);
        chk({name, "_hilo"}, {hi, lo}, {ehi, elo});
    endtask

    initial begin
        logic [63:0] m;
        logic [31:0] hold_hi;
        int          ndone;
        logic [1:0]  ro;
        logic [31:0] ra, rb;

        vecs[0] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[1] = '{2'b00, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[2] = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3] = '{2'b11, 32'd100,      32'h00000000, 32'd100,      32'hFFFFFFFF};
        vecs[4] = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[5] = '{2'b10, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
        vecs[6] = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[7] = '{2'b11, 32'd7,        32'd2,        32'd1,        32'd3};
        vecs[8] = '{2'b10, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
        vecs[9] = '{2'b01, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};

        reset = 1'b1; start = 1'b0; op = 2'b00; ea = '0; eb = '0;
        whi = 1'b0; wlo = 1'b0; flush = 1'b0;
        tick(); tick();
        reset = 1'b0;
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        chk("rst_busy_done", {62'd0, busy, done}, 64'd0);
        tick();

        // Directed vector table
        for (int i = 0; i < 10; i++)
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);

        // Done is a single-cycle pulse
        tick();
        chk("done_pulse_width", 64'(done), 64'd0);

        // Randomized operations against the model
        for (int i = 0; i < 30; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 20));
                2: rb = 32'hFFFFFFFF;
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 9) == 0) ra = 32'h80000000;
            m = model(ro, ra, rb);
            run_op($sformatf("rnd%0d_op%0d_%h_%h", i, ro, ra, rb), ro, ra, rb, m[63:32], m[31:0]);
        end

        // Flush mid-divide leaves preloaded HI/LO untouched
        tick();
        whi = 1'b1; ea = 32'h11; tick();
        whi = 1'b0; wlo = 1'b1; ea = 32'h22; tick();
        wlo = 1'b0;
        chk("mt_hilo", {hi, lo}, {32'h11, 32'h22});
        start = 1'b1; op = 2'b11; ea = 32'd1000; eb = 32'd3;
        tick();
        start = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_busy", 64'(busy), 64'd0);
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) ndone++;
            tick();
        end
        chk("flush_no_done", 64'(ndone), 64'd0);
        chk("flush_hilo", {hi, lo}, {32'h11, 32'h22});

        // flush in IDLE does not block a start
        start = 1'b1; flush = 1'b1; op = 2'b01; ea = 32'd3; eb = 32'd5;
        tick();
        start = 1'b0; flush = 1'b0;
        chk("idle_flush_start", 64'(busy), 64'd1);
        for (int i = 0; i < 40 && !done; i++) tick();
        chk("idle_flush_res", {hi, lo}, {32'd0, 32'd15});

        // start + whi together: whi ignored; start/whi while busy ignored
        tick();
        hold_hi = hi;
        start = 1'b1; whi = 1'b1; op = 2'b01; ea = 32'd9; eb = 32'd4;
        tick();
        start = 1'b0; whi = 1'b0;
        chk("start_whi_hi", 64'(hi), 64'(hold_hi));
        for (int i = 0; i < 5; i++) tick();
        start = 1'b1; whi = 1'b1; wlo = 1'b1; op = 2'b10; ea = 32'hDEAD; eb = 32'd2;
        tick();
        start = 1'b0; whi = 1'b0; wlo = 1'b0;
        chk("busy_whi_hilo", {hi, lo}, {hold_hi, 32'd15});
        ndone = 0;
        for (int i = 0; i < 80; i++) begin
            if (done) begin
                ndone++;
                chk("busy_start_res", {hi, lo}, {32'd0, 32'd36});
            end
            tick();
        end
        chk("busy_start_ndone", 64'(ndone), 64'd1);
        chk("busy_start_final", {hi, lo}, {32'd0, 32'd36});

        // Reset mid-multiply, then a new start is accepted
        start = 1'b1; op = 2'b00; ea = 32'd1234; eb = 32'hFFFFFF00;
        tick();
        start = 1'b0;
        for (int i = 0; i < 19; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_hilo", {hi, lo}, 64'd0);
        chk("midrst_busy_done", {62'd0, busy, done}, 64'd0);
        run_op("after_rst", 2'b01, 32'd6, 32'd7, 32'd0, 32'd42);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
